vram_cpu_port: RTL and testbench

- CPU-side writer/reader for the six 1-bpp VRAM planes: three foreground and three background.
- The video display processor consumes these planes. This block is the producing end of that path.
- Decodes Z80 memory accesses to the VRAM window and the plane-select I/O ports.
- Arbitrates the shared VRAM address bus against VDP fetch slots, inserting CPU wait states until each access completes.

---
 rtl/vram_cpu_port_pkg.sv | 33 +++
 rtl/vram_cpu_port_if.sv | 32 +++
 rtl/vram_cpu_port_strobe_edge.sv | 18 +
 rtl/vram_cpu_port.sv | 99 +++++++++
 tb/tb_vram_cpu_port.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/vram_cpu_port_pkg.sv
// Shared types and defaults for the CPU-side VRAM plane port.
// Plane order on the 48-bit read bus and the 6-bit write enable: fg1..fg3, bg1..bg3.
package vram_cpu_port_pkg;

  localparam logic [15:0] VRAM_BASE_DEF  = 16'hEC00;
  localparam logic [15:0] VRAM_SIZE_DEF  = 16'h1400;
  localparam logic [7:0]  PORT_RSEL_DEF  = 8'hF1;
  localparam logic [7:0]  PORT_WMASK_DEF = 8'hF2;

  localparam int NUM_PLANES = 6;
  localparam int AW         = 13;
  localparam int DW         = 8;

  localparam int PL_FG1 = 0;
  localparam int PL_FG2 = 1;
  localparam int PL_FG3 = 2;
  localparam int PL_BG1 = 3;
  localparam int PL_BG2 = 4;
  localparam int PL_BG3 = 5;

  typedef enum logic [2:0] {IDLE, ARB, WR, RD0, RD1, DONE} state_e;

  // Read select 1..6 picks a plane; 0 and 7 read as open bus.
  function automatic logic [DW-1:0] plane_byte(logic [NUM_PLANES*DW-1:0] q, logic [2:0] sel);
    int idx;
    if (int'(sel) >= PL_FG1 + 1 && int'(sel) <= PL_BG3 + 1) begin
      idx = int'(sel) - 1;
      return q[idx*DW +: DW];
    end
    return '1;
  endfunction

endpackage

// File: rtl/vram_cpu_port_if.sv
// CPU bus, VDP arbitration and plane-memory signals of the VRAM CPU port.
interface vram_cpu_port_if;
  import vram_cpu_port_pkg::*;

  logic [15:0]            cpu_addr;
  logic [7:0]             cpu_din;
  logic                   cpu_mreq;
  logic                   cpu_iorq;
  logic                   cpu_rd;
  logic                   cpu_wr;
  logic [DW-1:0]          cpu_dout;
  logic                   cpu_wait;
  logic                   vdp_slot;
  logic [AW-1:0]          vdp_addr;
  logic [AW-1:0]          vram_addr;
  logic [DW-1:0]          vram_wdata;
  logic [NUM_PLANES-1:0]  vram_we;
  logic [NUM_PLANES*DW-1:0] vram_q;

  modport slave (
    input  cpu_addr, cpu_din, cpu_mreq, cpu_iorq, cpu_rd, cpu_wr,
    input  vdp_slot, vdp_addr, vram_q,
    output cpu_dout, cpu_wait, vram_addr, vram_wdata, vram_we
  );

  modport master (
    output cpu_addr, cpu_din, cpu_mreq, cpu_iorq, cpu_rd, cpu_wr,
    output vdp_slot, vdp_addr, vram_q,
    input  cpu_dout, cpu_wait, vram_addr, vram_wdata, vram_we
  );

endinterface

// File: rtl/vram_cpu_port_strobe_edge.sv
// Registered rising-edge detector: pulses for the first cycle a level strobe is high.
module vram_cpu_port_strobe_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) d_q <= 1'b0;
    else       d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/vram_cpu_port.sv
// Z80-side access port to the six 1-bpp VRAM planes, arbitrating the shared
// plane address bus against VDP fetch slots and stalling the CPU with WAIT.
module vram_cpu_port
  import vram_cpu_port_pkg::*;
#(
  parameter logic [15:0] VRAM_BASE  = VRAM_BASE_DEF,
  parameter logic [15:0] VRAM_SIZE  = VRAM_SIZE_DEF,
  parameter logic [7:0]  PORT_RSEL  = PORT_RSEL_DEF,
  parameter logic [7:0]  PORT_WMASK = PORT_WMASK_DEF
) (
  input  logic            clk_i,
  input  logic            reset_i,
  vram_cpu_port_if.slave  bus
);

  state_e                state_q, state_d;
  logic [AW-1:0]         caddr_q, caddr_d;
  logic [DW-1:0]         cdata_q, cdata_d;
  logic                  dir_q, dir_d;
  logic [DW-1:0]         dout_q, dout_d;
  logic [2:0]            rsel_q;
  logic [NUM_PLANES-1:0] wmask_q;
  logic [NUM_PLANES-1:0] we_c;
  logic [DW-1:0]         wdata_c;

  // 17-bit compare so a window ending at 16'hFFFF does not wrap.
  logic [16:0] addr_x, lo_x, hi_x;
  logic        win, io_wr, win_rise, io_rise;

  assign addr_x = {1'b0, bus.cpu_addr};
  assign lo_x   = {1'b0, VRAM_BASE};
  assign hi_x   = lo_x + {1'b0, VRAM_SIZE};
  assign win    = bus.cpu_mreq & (bus.cpu_rd | bus.cpu_wr) & (addr_x >= lo_x) & (addr_x < hi_x);
  assign io_wr  = bus.cpu_iorq & bus.cpu_wr;

  vram_cpu_port_strobe_edge u_win_edge (.clk_i(clk_i), .rst_i(reset_i), .d_i(win),   .rise_o(win_rise));
  vram_cpu_port_strobe_edge u_io_edge  (.clk_i(clk_i), .rst_i(reset_i), .d_i(io_wr), .rise_o(io_rise));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      caddr_q <= '0;
      cdata_q <= '0;
      dir_q   <= 1'b0;
      dout_q  <= '1;
      rsel_q  <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
      dir_q   <= dir_d;
      dout_q  <= dout_d;
      if (io_rise && bus.cpu_addr[7:0] == PORT_RSEL)  rsel_q  <= bus.cpu_din[2:0];
      if (io_rise && bus.cpu_addr[7:0] == PORT_WMASK) wmask_q <= bus.cpu_din[5:0];
    end
  end

  always_comb begin
    state_d = state_q;
    caddr_d = caddr_q;
    cdata_d = cdata_q;
    dir_d   = dir_q;
    dout_d  = dout_q;
    we_c    = '0;
    wdata_c = '0;
    case (state_q)
      IDLE: if (win_rise) begin
        // Window offset mod 2^13 only needs the low address bits.
        caddr_d = bus.cpu_addr[AW-1:0] - VRAM_BASE[AW-1:0];
        cdata_d = bus.cpu_din;
        dir_d   = bus.cpu_wr;
        state_d = ARB;
      end
      ARB:  if (!bus.vdp_slot) state_d = dir_q ? WR : RD0;
      WR:   if (!bus.vdp_slot) begin
        we_c    = wmask_q;
        wdata_c = cdata_q;
        state_d = DONE;
      end else begin
        state_d = ARB;
      end
      RD0:  state_d = bus.vdp_slot ? ARB : RD1;
      RD1:  begin
        dout_d  = plane_byte(bus.vram_q, rsel_q);
        state_d = DONE;
      end
      DONE: if (!win) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.cpu_dout   = dout_q;
  assign bus.cpu_wait   = win & (state_q != DONE) & ~reset_i;
  assign bus.vram_addr  = bus.vdp_slot ? bus.vdp_addr : caddr_q;
  assign bus.vram_we    = we_c;
  assign bus.vram_wdata = wdata_c;

endmodule

// File: tb/tb_vram_cpu_port.sv
// Scoreboard bench for vram_cpu_port: expected plane writes and read bytes are
// queued at stimulus time and retired when the DUT writes or releases WAIT.
module tb_vram_cpu_port;
  import vram_cpu_port_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_cpu_port_if bus();

  vram_cpu_port dut (.clk_i(clk), .reset_i(rst), .bus(bus));

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
    logic [5:0]  we;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  wr_t        mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         wr_cnt = 0;
  int         wr_before;
  logic [2:0] m_rsel = '0;
  logic [5:0] m_wmask = '0;

  localparam logic [47:0] Q0 = 48'hC6_B5_5A_33_22_11;
  localparam logic [47:0] Q1 = 48'h9E_8D_7C_6B_4A_39;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [47:0] q, input logic [2:0] s);
    logic [47:0] t;
    if (s == 3'd0 || s == 3'd7) return 8'hFF;
    t = q >> (8 * (int'(s) - 1));
    return t[7:0];
  endfunction

  // Plane-write monitor; also checks VDP slot ownership of the bus.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.vdp_slot) begin
        chk("slot_we", 32'(bus.vram_we), 32'h0);
        chk("slot_addr", 32'(bus.vram_addr), 32'(bus.vdp_addr));
      end
      if (bus.vram_we != '0) begin
        wr_cnt++;
        if (wr_q.size() == 0) begin
          chk("unexp_we", 32'(bus.vram_we), 32'h0);
        end else begin
          mon_e = wr_q.pop_front();
          chk("we", 32'(bus.vram_we), 32'(mon_e.we));
          chk("waddr", 32'(bus.vram_addr), 32'(mon_e.addr));
          chk("wdata", 32'(bus.vram_wdata), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic io_out(input logic [7:0] port, input logic [7:0] d);
    @(posedge clk); #1;
    bus.cpu_addr = {8'h00, port};
    bus.cpu_din  = d;
    bus.cpu_iorq = 1'b1;
    bus.cpu_wr   = 1'b1;
    @(posedge clk); #1;
    bus.cpu_iorq = 1'b0;
    bus.cpu_wr   = 1'b0;
    if (port == 8'hF1) m_rsel = d[2:0];
    else if (port == 8'hF2) m_wmask = d[5:0];
  endtask

  task automatic slot_pulse(input int k, input int n, input logic [12:0] va, input logic [47:0] qa);
    repeat (k) @(posedge clk);
    #1;
    bus.vdp_slot = 1'b1;
    bus.vdp_addr = va;
    repeat (n) @(posedge clk);
    #1;
    bus.vdp_slot = 1'b0;
    bus.vram_q   = qa;
  endtask

  // exp_wait counts WAIT cycles after the strobe-rise cycle; -1 skips that check.
  task automatic mem(input logic [15:0] addr, input logic [7:0] d, input logic is_wr,
                     input int exp_wait, input int hold, input logic [47:0] q_fin);
    logic        inwin;
    logic [15:0] t;
    int          cnt;
    inwin = ({1'b0, addr} >= 17'h0EC00) && ({1'b0, addr} < 17'h10000);
    t = addr - 16'hEC00;
    if (inwin && is_wr && m_wmask != '0) wr_q.push_back('{t[12:0], d, m_wmask});
    if (inwin && !is_wr) rd_q.push_back(exp_rd(q_fin, m_rsel));
    @(posedge clk); #1;
    bus.cpu_addr = addr;
    bus.cpu_din  = d;
    bus.cpu_mreq = 1'b1;
    bus.cpu_rd   = ~is_wr;
    bus.cpu_wr   = is_wr;
    @(negedge clk);
    chk("wait_rise", 32'(bus.cpu_wait), 32'(inwin));
    if (inwin) begin
      cnt = 0;
      while (cnt < 100) begin
        @(negedge clk);
        if (!bus.cpu_wait) break;
        cnt++;
      end
      if (cnt == 100) chk("wait_timeout", 32'(bus.cpu_wait), 32'h0);
      if (exp_wait >= 0) chk("wait_cycles", cnt, exp_wait);
      chk("vram_addr", 32'(bus.vram_addr), 32'(t[12:0]));
      if (!is_wr) chk("cpu_dout", 32'(bus.cpu_dout), 32'(rd_q.pop_front()));
    end else begin
      repeat (3) begin
        @(negedge clk);
        chk("nowin_wait", 32'(bus.cpu_wait), 32'h0);
      end
    end
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    bus.cpu_mreq = 1'b0;
    bus.cpu_rd   = 1'b0;
    bus.cpu_wr   = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.cpu_mreq = 1'b0; bus.cpu_iorq = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    bus.vdp_slot = 1'b0; bus.vdp_addr = 13'h0AA; bus.vram_q = Q0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", 32'(bus.cpu_dout), 32'hFF);
    chk("rst_wait", 32'(bus.cpu_wait), 32'h0);
    chk("rst_we", 32'(bus.vram_we), 32'h0);
    chk("rst_wdata", 32'(bus.vram_wdata), 32'h0);
    chk("rst_addr", 32'(bus.vram_addr), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    io_out(8'hF2, 8'h3F);
    mem(16'hEC00, 8'hA5, 1'b1, 2, 0, Q0);
    io_out(8'hF1, 8'h04);
    mem(16'hFFFF, 8'h00, 1'b0, 3, 0, Q0);

    // VDP owns the bus for the first 5 cycles of this write.
    fork slot_pulse(1, 5, 13'h1234, Q0); join_none
    mem(16'hF000, 8'h3C, 1'b1, 6, 0, Q0);

    // VDP steals the RD0 cycle; data comes from the retried RD1.
    fork slot_pulse(3, 2, 13'h0777, Q1); join_none
    mem(16'hEC10, 8'h00, 1'b0, 6, 0, Q1);

    io_out(8'hF1, 8'h00);
    mem(16'hEC20, 8'h00, 1'b0, 3, 0, Q1);
    io_out(8'hF1, 8'h07);
    mem(16'hEC21, 8'h00, 1'b0, 3, 0, Q1);
    io_out(8'hF1, 8'h01);
    mem(16'hEC22, 8'h00, 1'b0, 3, 0, Q1);
    io_out(8'hF1, 8'h06);
    mem(16'hFFFE, 8'h00, 1'b0, 3, 0, Q1);

    wr_before = wr_cnt;
    mem(16'hEBFF, 8'h55, 1'b1, -1, 0, Q1);
    mem(16'hEBFF, 8'h00, 1'b0, -1, 0, Q1);
    chk("below_win_writes", wr_cnt, wr_before);

    io_out(8'hF2, 8'h00);
    wr_before = wr_cnt;
    mem(16'hEC05, 8'h66, 1'b1, 2, 0, Q1);
    chk("mask0_writes", wr_cnt, wr_before);

    io_out(8'hF2, 8'h15);
    io_out(8'hF3, 8'h3F);
    wr_before = wr_cnt;
    mem(16'hED00, 8'h99, 1'b1, 2, 10, Q1);
    chk("held_strobe_writes", wr_cnt, wr_before + 1);

    // Reset lands in the WR cycle of a write.
    io_out(8'hF2, 8'h3F);
    io_out(8'hF1, 8'h02);
    @(posedge clk); #1;
    bus.cpu_addr = 16'hEC40; bus.cpu_din = 8'h77;
    bus.cpu_mreq = 1'b1; bus.cpu_wr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("we_before_rst", 32'(bus.vram_we), 32'h3F);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_we", 32'(bus.vram_we), 32'h0);
    chk("rst_mid_wait", 32'(bus.cpu_wait), 32'h0);
    @(posedge clk); #1;
    bus.cpu_mreq = 1'b0; bus.cpu_wr = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    m_rsel = '0; m_wmask = '0;

    mem(16'hEC50, 8'h00, 1'b0, 3, 0, Q1);
    wr_before = wr_cnt;
    mem(16'hEC51, 8'h12, 1'b1, 2, 0, Q1);
    chk("post_rst_writes", wr_cnt, wr_before);
    chk("wr_q_empty", wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
